// File: rtl/fix_ari_mac.sv
// fix_ari_mac: 3-stage pipelined signed fixed-point multiply / multiply-accumulate
// with selectable rounding, output saturation and a sticky accumulator overflow flag.
module fix_ari_mac #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int GUARD = 8,
    localparam int ACC_W = 2 * WIDTH + GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic             in_mac,
    input  logic             in_clr,
    input  logic [1:0]       in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [ACC_W-1:0] out_full,
    output logic             out_sat,
    output logic             acc_ovf
);
    localparam logic signed [ACC_W:0] ONE  = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] HALF = ONE <<< (FRAC - 1);
    localparam logic signed [ACC_W:0] HI   = {{(ACC_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] LO   = {{(ACC_W-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    logic                      adv;
    logic                      v1_q, mac1_q, clr1_q;
    logic [1:0]                rnd1_q;
    logic signed [WIDTH-1:0]   a1_q, b1_q;
    logic                      v2_q, mac2_q, clr2_q;
    logic [1:0]                rnd2_q;
    logic signed [2*WIDTH-1:0] prod2_q, prod2_d;
    logic signed [ACC_W-1:0]   prod_ext, acc_q, acc_d, v_d, out_full_q;
    logic signed [ACC_W:0]     sum, rnd_add, rnd_sum, rnd_val;
    logic                      acc_clip, acc_ovf_q, acc_ovf_d;
    logic                      out_valid_q, out_sat_q, out_sat_d;
    logic [WIDTH-1:0]          out_data_q, out_data_d;

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign prod2_d  = (2*WIDTH)'(a1_q) * (2*WIDTH)'(b1_q);

    always_comb begin
        prod_ext   = ACC_W'(prod2_q);
        sum        = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
        acc_clip   = sum[ACC_W] ^ sum[ACC_W-1];
        acc_d      = clr2_q ? prod_ext
                   : acc_clip ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
        v_d        = mac2_q ? acc_d : prod_ext;
        // Rounding runs one bit wider than the accumulator so the bias add cannot wrap.
        rnd_add    = rnd2_q == 2'b01 ? HALF
                   : rnd2_q == 2'b10 ? HALF - ONE + (ACC_W+1)'(v_d[FRAC]) : '0;
        rnd_sum    = (ACC_W+1)'(v_d) + rnd_add;
        rnd_val    = rnd_sum >>> FRAC;
        out_sat_d  = rnd_val > HI || rnd_val < LO;
        out_data_d = rnd_val > HI ? HI[WIDTH-1:0]
                   : rnd_val < LO ? LO[WIDTH-1:0] : rnd_val[WIDTH-1:0];
        acc_ovf_d  = !clr2_q && (acc_ovf_q || acc_clip);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            mac1_q  <= 1'b0;
            clr1_q  <= 1'b0;
            rnd1_q  <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            v2_q    <= 1'b0;
            mac2_q  <= 1'b0;
            clr2_q  <= 1'b0;
            rnd2_q  <= '0;
            prod2_q <= '0;
        end else if (adv) begin
            v1_q    <= in_valid;
            mac1_q  <= in_mac;
            clr1_q  <= in_clr;
            rnd1_q  <= in_rnd;
            a1_q    <= in_data1;
            b1_q    <= in_data2;
            v2_q    <= v1_q;
            mac2_q  <= mac1_q;
            clr2_q  <= clr1_q;
            rnd2_q  <= rnd1_q;
            prod2_q <= prod2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_full_q  <= '0;
            out_sat_q   <= 1'b0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_data_q <= out_data_d;
                out_full_q <= v_d;
                out_sat_q  <= out_sat_d;
            end
            if (v2_q && mac2_q) begin
                acc_q     <= acc_d;
                acc_ovf_q <= acc_ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_full  = out_full_q;
    assign out_sat   = out_sat_q;
    assign acc_ovf   = acc_ovf_q;
endmodule
